// File: rtl/csa_multiword_adder_seq_if.sv
// Operand/result handshake bundle for csa_multiword_adder_seq.
// SUB_EN adds the op_sub control bit to the operand side.
interface csa_multiword_adder_seq_if #(
  parameter int WORDS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [16*WORDS-1:0]   op_a;
  logic [16*WORDS-1:0]   op_b;
  logic                  op_cin;
`ifdef SUB_EN
  logic                  op_sub;
`endif
  logic                  out_valid;
  logic                  out_ready;
  logic [16*WORDS-1:0]   sum;
  logic                  cout;
  logic                  busy;

`ifdef SUB_EN
  modport master (
    output in_valid, op_a, op_b, op_cin, op_sub, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );
  modport slave (
    input  in_valid, op_a, op_b, op_cin, op_sub, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
`else
  modport master (
    output in_valid, op_a, op_b, op_cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );
  modport slave (
    input  in_valid, op_a, op_b, op_cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
`endif
endinterface

// File: rtl/csa_multiword_adder_seq.sv
// Wide adder that streams WORDS x 16-bit words LSW-first through one 16-bit carry-select adder.
// Optional macro SUB_EN adds op_sub (A - B via inverted B and initial carry of 1).

module carry_select_adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic       c;
  logic [4:0] r0;
  logic [4:0] r1;

  // Each 4-bit group precomputes both carry-in cases; the incoming carry only selects.
  always_comb begin
    c   = cin;
    r0  = '0;
    r1  = '0;
    sum = '0;
    for (int g = 0; g < 4; g++) begin
      r0 = {1'b0, a[4*g +: 4]} + {1'b0, b[4*g +: 4]};
      r1 = r0 + 5'd1;
      sum[4*g +: 4] = c ? r1[3:0] : r0[3:0];
      c = c ? r1[4] : r0[4];
    end
    cout = c;
  end
endmodule

// state | meaning
// IDLE  | waiting for an operand bundle, in_ready high
// RUN   | one word per cycle through the adder, idx selects the word
// DONE  | result valid, held until out_ready
module csa_multiword_adder_seq #(
  parameter int WORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  csa_multiword_adder_seq_if.slave   bus
);
  localparam int W     = 16 * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic [W-1:0]     sum_reg;
  logic             cout_reg;
`ifdef SUB_EN
  logic             sub_reg;
`endif
  logic [15:0]      add_a;
  logic [15:0]      add_b;
  logic [15:0]      add_sum;
  logic             add_cout;
  logic             accept;
  logic             last;

  assign accept = bus.in_valid && (state == IDLE);
  assign last   = (idx == IDX_LAST);

  always_comb begin
    add_a = '0;
    add_b = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (idx == IDX_W'(k)) begin
        add_a = a_reg[16*k +: 16];
        add_b = b_reg[16*k +: 16];
      end
    end
`ifdef SUB_EN
    if (sub_reg) add_b = ~add_b;
`endif
  end

  carry_select_adder_16bit u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      carry    <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      cout_reg <= 1'b0;
`ifdef SUB_EN
      sub_reg  <= 1'b0;
`endif
    end else if (accept) begin
      a_reg <= bus.op_a;
      b_reg <= bus.op_b;
      idx   <= '0;
`ifdef SUB_EN
      sub_reg <= bus.op_sub;
      carry   <= bus.op_sub ? 1'b1 : bus.op_cin;
`else
      carry   <= bus.op_cin;
`endif
    end else if (state == RUN) begin
      for (int k = 0; k < WORDS; k++) begin
        if (idx == IDX_W'(k)) sum_reg[16*k +: 16] <= add_sum;
      end
      carry <= add_cout;
      // idx wraps to 0 on the last word so it never leaves 0..WORDS-1
      if (last) begin
        idx      <= '0;
        cout_reg <= add_cout;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.sum       = sum_reg;
  assign bus.cout      = cout_reg;
endmodule

// File: tb/tb_csa_multiword_adder_seq.sv
// Directed bench for csa_multiword_adder_seq: WORDS=4 main instance plus a WORDS=1 instance.
// Define SUB_EN for both RTL and bench to include the subtract vectors.
module tb_csa_multiword_adder_seq;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  csa_multiword_adder_seq_if #(.WORDS(4)) bus4 ();
  csa_multiword_adder_seq_if #(.WORDS(1)) bus1 ();

  csa_multiword_adder_seq #(.WORDS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  csa_multiword_adder_seq #(.WORDS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // One WORDS=4 transaction; hold>0 keeps out_ready low and pushes a rival in_valid meanwhile.
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic cin, input bit scramble, input int hold,
                        input logic [63:0] esum, input logic ecout);
    int n;
    int lat;
    bit seen;
    n = 0;
    @(negedge clk);
    while (!bus4.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rdy"}, 64'(bus4.in_ready), 64'd1);
    bus4.op_a     = a;
    bus4.op_b     = b;
    bus4.op_cin   = cin;
    bus4.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus4.in_valid = 1'b0;
    lat  = 1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (scramble) begin
        bus4.op_a   = ~bus4.op_a ^ 64'(i);
        bus4.op_b   = bus4.op_b + 64'h0001_0001_0001_0001;
        bus4.op_cin = ~bus4.op_cin;
      end
      @(negedge clk);
      if (bus4.out_valid) seen = 1;
      else begin
        @(posedge clk);
        #1;
        lat++;
      end
    end
    chk({tag, "_lat"}, 64'(lat), 64'd5);
    chk({tag, "_sum"}, bus4.sum, esum);
    chk({tag, "_cout"}, 64'(bus4.cout), 64'(ecout));
    for (int h = 0; h < hold; h++) begin
      bus4.in_valid = 1'b1;
      bus4.op_a     = 64'h5555_5555_5555_5555;
      bus4.op_b     = 64'hAAAA_AAAA_AAAA_AAAA;
      bus4.op_cin   = 1'b1;
      @(negedge clk);
      chk({tag, "_hold_ov"}, 64'(bus4.out_valid), 64'd1);
      chk({tag, "_hold_rdy"}, 64'(bus4.in_ready), 64'd0);
      chk({tag, "_hold_sum"}, bus4.sum, esum);
      chk({tag, "_hold_cout"}, 64'(bus4.cout), 64'(ecout));
    end
    bus4.in_valid = 1'b0;
    @(negedge clk);
    bus4.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus4.out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_drop_ov"}, 64'(bus4.out_valid), 64'd0);
    chk({tag, "_idle_rdy"}, 64'(bus4.in_ready), 64'd1);
    chk({tag, "_idle_busy"}, 64'(bus4.busy), 64'd0);
    chk({tag, "_keep_sum"}, bus4.sum, esum);
  endtask

  initial begin
    int lat1;
    bit seen1;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus4.in_valid = 1'b0; bus4.op_a = '0; bus4.op_b = '0; bus4.op_cin = 1'b0; bus4.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.op_a = '0; bus1.op_b = '0; bus1.op_cin = 1'b0; bus1.out_ready = 1'b0;
`ifdef SUB_EN
    bus4.op_sub = 1'b0;
    bus1.op_sub = 1'b0;
`endif
    #12;
    chk("rst_rdy", 64'(bus4.in_ready), 64'd1);
    chk("rst_ov", 64'(bus4.out_valid), 64'd0);
    chk("rst_busy", 64'(bus4.busy), 64'd0);
    chk("rst_sum", bus4.sum, 64'd0);
    chk("rst_cout", 64'(bus4.cout), 64'd0);
    chk("rst1_rdy", 64'(bus1.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("chain", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 0, 0, 64'h0000_0000_0001_0000, 1'b0);
    run_op("wrap",  64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 0, 0, 64'd0, 1'b1);
    run_op("msb",   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b0, 0, 0, 64'd1, 1'b1);
    run_op("mix",   64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 0, 0,
           64'h2345_6789_ABCD_F001, 1'b0);
    run_op("toggle", 64'd100, 64'd23, 1'b1, 1, 0, 64'd124, 1'b0);
    run_op("bp", 64'h0001_0002_0003_0004, 64'h000F_000E_000D_000C, 1'b0, 0, 10,
           64'h0010_0010_0010_0010, 1'b0);

`ifdef SUB_EN
    bus4.op_sub = 1'b1;
    run_op("sub_neg", 64'd5, 64'd7, 1'b0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    run_op("sub_pos", 64'd7, 64'd5, 1'b0, 0, 0, 64'd2, 1'b1);
    bus4.op_sub = 1'b0;
`endif

    // Abort a transaction with reset while it is still in RUN.
    @(negedge clk);
    bus4.op_a = 64'h0123_4567_89AB_CDEF;
    bus4.op_b = 64'h1111_1111_1111_1111;
    bus4.op_cin = 1'b1;
    bus4.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus4.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_busy", 64'(bus4.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rdy", 64'(bus4.in_ready), 64'd1);
    chk("mid_rst_ov", 64'(bus4.out_valid), 64'd0);
    chk("mid_rst_busy", 64'(bus4.busy), 64'd0);
    chk("mid_rst_sum", bus4.sum, 64'd0);
    chk("mid_rst_cout", 64'(bus4.cout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ov", 64'(bus4.out_valid), 64'd0);

    // WORDS=1 instance
    bus1.op_a = 16'hFFFF;
    bus1.op_b = 16'h0002;
    bus1.op_cin = 1'b0;
    bus1.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    lat1  = 1;
    seen1 = 0;
    for (int i = 0; i < 20 && !seen1; i++) begin
      @(negedge clk);
      if (bus1.out_valid) seen1 = 1;
      else begin
        @(posedge clk);
        #1;
        lat1++;
      end
    end
    chk("w1_lat", 64'(lat1), 64'd2);
    chk("w1_sum", 64'(bus1.sum), 64'h0001);
    chk("w1_cout", 64'(bus1.cout), 64'd1);
    bus1.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus1.out_ready = 1'b0;
    @(negedge clk);
    chk("w1_drop_ov", 64'(bus1.out_valid), 64'd0);
    chk("w1_idle_rdy", 64'(bus1.in_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
